// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag indices and opcode legality for alu_pipe (honours ALU_PIPE_SHIFT_EN)
package alu_pkg;

    // Opcode encodings
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_NAND = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;

    // Bit positions inside the 4-bit flags bus {neg, ovf, carry, zero}
    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

    localparam int FLAG_W = 4;

    // Shifts only become legal opcodes when the shifter is built in
    function automatic logic is_legal_op(input logic [3:0] op);
`ifdef ALU_PIPE_SHIFT_EN
        return (op <= OP_SRA);
`else
        return (op <= OP_SUB);
`endif
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath: a/b/op to result/flags/err; shifter built only with ALU_PIPE_SHIFT_EN
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [3:0]        op_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [FLAG_W-1:0] flags_o,
    output logic              err_o
);

    // One extra bit on the adders exposes carry-out and borrow directly
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;

    assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_ext = {1'b0, a_i} - {1'b0, b_i};

    // Signed overflow: like-signed operands giving a differently-signed sum,
    // or unlike-signed operands whose difference takes the sign of b
    assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_ext[WIDTH-1]  != a_i[WIDTH-1]);
    assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_ext[WIDTH-1] != a_i[WIDTH-1]);

`ifdef ALU_PIPE_SHIFT_EN
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] srl_res;
    logic [WIDTH-1:0] sra_res;

    assign shamt   = b_i[SHW-1:0];
    assign sll_res = a_i << shamt;
    assign srl_res = a_i >> shamt;
    assign sra_res = $unsigned($signed(a_i) >>> shamt);
`endif

    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             illegal;

    // Opcode decode; illegal opcodes fall through to a zero result with err set
    always_comb begin
        res     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (op_i)
            OP_AND:  res = a_i & b_i;
            OP_NAND: res = ~(a_i & b_i);
            OP_OR:   res = a_i | b_i;
            OP_XOR:  res = a_i ^ b_i;
            OP_NOR:  res = ~(a_i | b_i);
            OP_XNOR: res = ~(a_i ^ b_i);
            OP_ADD: begin
                res   = sum_ext[WIDTH-1:0];
                carry = sum_ext[WIDTH];
                ovf   = add_ovf;
            end
            OP_SUB: begin
                res   = diff_ext[WIDTH-1:0];
                carry = diff_ext[WIDTH];
                ovf   = sub_ovf;
            end
`ifdef ALU_PIPE_SHIFT_EN
            OP_SLL:  res = sll_res;
            OP_SRL:  res = srl_res;
            OP_SRA:  res = sra_res;
`endif
            default: illegal = 1'b1;
        endcase
    end

    // Flags follow the final result, so an illegal op naturally reports zero only
    always_comb begin
        flags_o        = '0;
        flags_o[FLG_Z] = (res == '0);
        flags_o[FLG_C] = carry;
        flags_o[FLG_V] = ovf;
        flags_o[FLG_N] = res[WIDTH-1];
    end

    assign result_o = res;
    assign err_o    = illegal;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready pipelined ALU top; optional shifts via ALU_PIPE_SHIFT_EN
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    // Stage 1: captured operands
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [3:0]       s1_op_q;

    // Stage 2: registered outputs
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             err_q;

    // Next-state values from the combinational core
    logic [WIDTH-1:0] result_d;
    logic [3:0]       flags_d;
    logic             err_d;

    logic             s2_adv;
    logic             s1_adv;

    // A stage may move when the stage downstream of it is empty or draining
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .op_i     (s1_op_q),
        .result_o (result_d),
        .flags_o  (flags_d),
        .err_o    (err_d)
    );

    // Stage 1 valid bit; reset discards whatever was captured
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
        end
    end

    // Stage 1 operands load only on an accepted transfer; the valid bit gates them
    always_ff @(posedge clk) begin
        if (!rst && s1_adv && in_valid) begin
            s1_a_q  <= a;
            s1_b_q  <= b;
            s1_op_q <= op;
        end
    end

    // Stage 2 valid bit and result registers; held stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= result_d;
                flags_q  <= flags_d;
                err_q    <= err_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard testbench for alu_pipe (WIDTH=8), directed corners plus random traffic
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;
    logic       err;

    int n_vec = 0;
    int n_mis = 0;
    int n_out = 0;

    // {err, flags[3:0], result[7:0]}
    logic [12:0] sb[$];

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operand values
    function automatic logic [12:0] model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
        int ua = x;
        int ub = y;
        int sa = (ua >= 128) ? ua - 256 : ua;
        int sb_ = (ub >= 128) ? ub - 256 : ub;
        int sh = ub % 8;
        int r = 0;
        bit c = 0;
        bit v = 0;
        bit e = 0;
        logic [7:0] rr;
        case (o)
            4'd0: r = ua & ub;
            4'd1: r = ~(ua & ub) & 255;
            4'd2: r = ua | ub;
            4'd3: r = ua ^ ub;
            4'd4: r = ~(ua | ub) & 255;
            4'd5: r = ~(ua ^ ub) & 255;
            4'd6: begin
                r = ua + ub;
                c = (r > 255);
                v = (sa + sb_ > 127) || (sa + sb_ < -128);
                r = r & 255;
            end
            4'd7: begin
                r = (ua - ub) & 255;
                c = (ua < ub);
                v = (sa - sb_ > 127) || (sa - sb_ < -128);
            end
`ifdef ALU_PIPE_SHIFT_EN
            4'd8:  r = (ua << sh) & 255;
            4'd9:  r = ua >> sh;
            4'd10: r = (sa >>> sh) & 255;
`endif
            default: begin
                e = 1;
                r = 0;
            end
        endcase
        rr = r[7:0];
        return {e, rr[7], v, c, (rr == 8'h00), rr};
    endfunction

    // One clock: note whether the current inputs are accepted, then advance to the next falling edge
    task automatic tick(output bit acc);
        #1;
        acc = !rst && in_valid && in_ready;
        if (acc) sb.push_back(model(a, b, op));
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
        bit done = 0;
        a = x;
        b = y;
        op = o;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) tick(done);
        if (!done) begin
            n_vec++;
            n_mis++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 64 cycles");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] corners [4];
        corners[0] = 8'h00;
        corners[1] = 8'h7F;
        corners[2] = 8'h80;
        corners[3] = 8'hFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    // Monitor: pops the scoreboard on each output handshake and checks stall stability
    bit          prev_stall = 0;
    logic [12:0] prev_out;
    always @(negedge clk) begin
        logic [12:0] exp;
        #2;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", out_valid, 1'b1);
                chk("stall_hold_data", {err, flags, result}, prev_out);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1'b1, 1'b0);
                end else begin
                    exp = sb.pop_front();
                    chk("out_result", result, exp[7:0]);
                    chk("out_flags", flags, exp[11:8]);
                    chk("out_err", err, exp[12]);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {err, flags, result};
        end
    end

    initial begin
        bit acc;
        int nacc;
        int outs0;

        // Reset held two cycles with in_valid high
        rst = 1'b1;
        in_valid = 1'b1;
        a = 8'h12;
        b = 8'h34;
        op = OP_ADD;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", flags, 4'h0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        idle(2);

        // ADD streaming, back to back, with latency checks
        send(8'h7F, 8'h01, OP_ADD);
        chk("lat1_out_valid", out_valid, 1'b0);
        send(8'hFF, 8'h01, OP_ADD);
        chk("lat2_out_valid", out_valid, 1'b1);
        chk("add_7f_res", result, 8'h80);
        chk("add_7f_flags", flags, 4'b1100);
        idle(1);
        chk("add_ff_res", result, 8'h00);
        chk("add_ff_flags", flags, 4'b0011);
        idle(2);

        // SUB borrow and signed overflow
        send(8'h00, 8'h01, OP_SUB);
        idle(1);
        chk("sub_borrow_res", result, 8'hFF);
        chk("sub_borrow_flags", flags, 4'b1010);
        send(8'h80, 8'h01, OP_SUB);
        idle(1);
        chk("sub_ovf_res", result, 8'h7F);
        chk("sub_ovf_flags", flags, 4'b0100);
        idle(2);

        // Illegal op / shift
        send(8'h80, 8'h03, 4'd9);
        idle(1);
`ifdef ALU_PIPE_SHIFT_EN
        chk("srl_res", result, 8'h10);
        chk("srl_err", err, 1'b0);
        send(8'h80, 8'h03, 4'd10);
        idle(1);
        chk("sra_res", result, 8'hF0);
        chk("sra_flags", flags, 4'b1000);
`else
        chk("ill9_res", result, 8'h00);
        chk("ill9_flags", flags, 4'b0001);
        chk("ill9_err", err, 1'b1);
`endif
        send(8'h55, 8'hAA, 4'd13);
        idle(1);
        chk("ill13_err", err, 1'b1);
        chk("ill13_flags", flags, 4'b0001);
        idle(2);

        // Back-pressure: four NANDs with the consumer stalled for five cycles
        outs0 = n_out;
        out_ready = 1'b0;
        a = 8'hF0;
        b = 8'hFF;
        op = OP_NAND;
        in_valid = 1'b1;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            if (acc) nacc++;
        end
        chk("bp_accepts", nacc, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_held_res", result, 8'h0F);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && nacc < 4; i++) begin
            tick(acc);
            if (acc) nacc++;
        end
        chk("bp_total_accepts", nacc, 4);
        idle(6);
        chk("bp_outputs", n_out - outs0, 4);
        chk("bp_sb_empty", sb.size(), 0);

        // Reset while stalled with a valid output
        out_ready = 1'b0;
        send(8'h33, 8'h11, OP_ADD);
        in_valid = 1'b0;
        for (int i = 0; i < 8 && !out_valid; i++) tick(acc);
        chk("ms_out_valid_before", out_valid, 1'b1);
        rst = 1'b1;
        sb.delete();
        tick(acc);
        rst = 1'b0;
        chk("ms_out_valid", out_valid, 1'b0);
        chk("ms_result", result, 8'h00);
        chk("ms_flags", flags, 4'h0);
        chk("ms_err", err, 1'b0);
        #1;
        chk("ms_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        send(8'h40, 8'h40, OP_ADD);
        chk("ms_lat1", out_valid, 1'b0);
        idle(1);
        chk("ms_lat2", out_valid, 1'b1);
        chk("ms_new_res", result, 8'h80);
        idle(2);

        // Random traffic with random back-pressure and rare resets
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = rnd_byte();
            b = rnd_byte();
            op = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 399) == 0);
            if (rst) sb.delete();
            tick(acc);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        idle(8);
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
